// File: rtl/acc_result_reader.sv
// Drains len_i words from the accumulator result memory in address order onto a valid/ready stream.
// Latency: start_i -> first read 1 cycle -> dout_valid_o 2 cycles; 1 word/cycle while dout_ready_i is held high.
// Backpressure: reads stall when buffered + in-flight words reach 2, so the 2-entry buffer never overflows.
// Build option ACC_READ_CLR_EN: each location is cleared one cycle after it is read.
module acc_result_reader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W:0]   len_i,
    output logic              mem_rd_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic              mem_clr_o,
    output logic [ADDR_W-1:0] mem_clr_addr_o,
    output logic [DATA_W-1:0] dout_o,
    output logic              dout_valid_o,
    input  logic              dout_ready_i,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   rd_cnt_q, rd_cnt_d;
    logic              zero_q, zero_d;

    logic              inflight_q;
    logic [DATA_W-1:0] buf_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        occ_q;

    logic              rd_issue;
    logic              last_rd;
    logic              bypass;
    logic              pop;
    logic              pop_buf;
    logic              push;
    logic [2:0]        outstanding;

    assign outstanding = {1'b0, occ_q} + {2'b00, inflight_q};

    // With the buffer empty, the word arriving from memory is shown directly; if it is
    // not taken this cycle it is captured, so dout_o stays stable until accepted.
    assign bypass       = (occ_q == 2'd0) && inflight_q;
    assign dout_valid_o = (occ_q != 2'd0) || inflight_q;
    assign dout_o       = bypass ? mem_data_i : buf_q[rd_ptr_q];
    assign pop          = dout_valid_o && dout_ready_i;
    assign pop_buf      = pop && !bypass;
    assign push         = inflight_q && !(bypass && pop);

    assign rd_issue    = (state_q == READ) && (outstanding < 3'd2);
    assign last_rd     = rd_issue && ((rd_cnt_q + (ADDR_W+1)'(1)) == len_q);
    assign mem_rd_en_o = rd_issue;
    assign mem_addr_o  = rd_cnt_q[ADDR_W-1:0];

    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == FINISH) && !zero_q;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        rd_cnt_d = rd_cnt_q;
        zero_d   = zero_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    len_d    = len_i;
                    rd_cnt_d = '0;
                    if (len_i == '0) begin
                        state_d = FINISH;
                        zero_d  = 1'b1;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                if (rd_issue) begin
                    rd_cnt_d = rd_cnt_q + (ADDR_W+1)'(1);
                end
                if (last_rd) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if ((outstanding == 3'd0) || ((outstanding == 3'd1) && pop)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                // A zero-length drain spends one extra cycle here so done_o lands two cycles after start_i.
                if (zero_q) begin
                    zero_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            rd_cnt_q   <= '0;
            zero_q     <= 1'b0;
            inflight_q <= 1'b0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            occ_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            rd_cnt_q   <= rd_cnt_d;
            zero_q     <= zero_d;
            inflight_q <= rd_issue;
            if (push) begin
                buf_q[wr_ptr_q] <= mem_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_buf) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_q + {1'b0, push} - {1'b0, pop_buf};
        end
    end

`ifdef ACC_READ_CLR_EN
    logic              clr_q;
    logic [ADDR_W-1:0] clr_addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_q      <= 1'b0;
            clr_addr_q <= '0;
        end else begin
            clr_q <= rd_issue;
            if (rd_issue) begin
                clr_addr_q <= mem_addr_o;
            end
        end
    end

    assign mem_clr_o      = clr_q;
    assign mem_clr_addr_o = clr_addr_q;
`else
    assign mem_clr_o      = 1'b0;
    assign mem_clr_addr_o = '0;
`endif

endmodule

// File: tb/tb_acc_result_reader.sv
// Bench for acc_result_reader: random and directed drains against a queue-based reference of the result memory.
module tb_acc_result_reader;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start_i = 1'b0;
    logic [ADDR_W:0]   len_i = '0;
    logic              mem_rd_en_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_data_i = '0;
    logic              mem_clr_o;
    logic [ADDR_W-1:0] mem_clr_addr_o;
    logic [DATA_W-1:0] dout_o;
    logic              dout_valid_o;
    logic              dout_ready_i = 1'b0;
    logic              busy_o;
    logic              done_o;

    acc_result_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .len_i(len_i),
        .mem_rd_en_o(mem_rd_en_o), .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i),
        .mem_clr_o(mem_clr_o), .mem_clr_addr_o(mem_clr_addr_o),
        .dout_o(dout_o), .dout_valid_o(dout_valid_o), .dout_ready_i(dout_ready_i),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: actual %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference memory contents and the image loaded into the simulated memory.
    logic [DATA_W-1:0] ref_mem  [DEPTH];
    logic [DATA_W-1:0] load_img [DEPTH];
    logic [DATA_W-1:0] tb_mem   [DEPTH];
    bit                load_req = 1'b0;

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < DEPTH; i++) tb_mem[i] <= load_img[i];
        end else if (mem_clr_o) begin
            tb_mem[mem_clr_addr_o] <= '0;
        end
        if (mem_rd_en_o) mem_data_i <= tb_mem[mem_addr_o];
        else             mem_data_i <= DATA_W'($urandom);
    end

    int rmode = 0;
    always @(posedge clk) begin
        #1;
        case (rmode)
            0:       dout_ready_i = 1'b1;
            1:       dout_ready_i = ~dout_ready_i;
            default: dout_ready_i = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Scoreboard monitor
    logic [DATA_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] addr_q[$];
    int                out_n = 0;
    int                acc_cnt = 0;
    int                done_cnt = 0;
    int                done_cyc = -1;
    int                first_rd = -1;
    int                first_vld = -1;
    bit                hold_p = 1'b0;
    logic [DATA_W-1:0] hold_d = '0;
`ifdef ACC_READ_CLR_EN
    bit                pend_p = 1'b0;
    logic [ADDR_W-1:0] pend_a = '0;
`endif

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            addr_q.delete();
            out_n  = 0;
            hold_p = 1'b0;
`ifdef ACC_READ_CLR_EN
            pend_p = 1'b0;
`endif
        end else begin
            if (hold_p) begin
                chk("hold_valid", dout_valid_o, 1);
                chk("hold_data", dout_o, hold_d);
            end
            if (dout_valid_o && first_vld < 0) first_vld = cyc;
            if (dout_valid_o && dout_ready_i) begin
                chk("word_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) chk("dout", dout_o, exp_q.pop_front());
                acc_cnt++;
            end
            if (mem_rd_en_o) begin
                chk("read_expected", addr_q.size() > 0, 1);
                chk("credit", out_n < 2, 1);
                if (addr_q.size() > 0) chk("rd_addr", mem_addr_o, addr_q.pop_front());
                if (first_rd < 0) first_rd = cyc;
            end
`ifdef ACC_READ_CLR_EN
            chk("clr_vld", mem_clr_o, pend_p);
            if (pend_p) chk("clr_addr", mem_clr_addr_o, pend_a);
            pend_p = mem_rd_en_o;
            pend_a = mem_addr_o;
`else
            chk("clr_off", {mem_clr_o, mem_clr_addr_o}, 0);
`endif
            out_n  = out_n + (mem_rd_en_o ? 1 : 0) - ((dout_valid_o && dout_ready_i) ? 1 : 0);
            hold_p = dout_valid_o && !dout_ready_i;
            hold_d = dout_o;
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic preload(input bit rnd);
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i]  = rnd ? DATA_W'($urandom) : DATA_W'(i * 3);
            load_img[i] = ref_mem[i];
        end
        load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_rd_en"}, mem_rd_en_o, 0);
        chk({tag, "_addr"}, mem_addr_o, 0);
        chk({tag, "_clr"}, mem_clr_o, 0);
        chk({tag, "_clr_addr"}, mem_clr_addr_o, 0);
        chk({tag, "_dout"}, dout_o, 0);
        chk({tag, "_valid"}, dout_valid_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_done"}, done_o, 0);
    endtask

    task automatic start_drain(input int len, output int n0, output int dc0);
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(ref_mem[i]);
            addr_q.push_back(ADDR_W'(i));
`ifdef ACC_READ_CLR_EN
            ref_mem[i] = '0;
`endif
        end
        first_rd  = -1;
        first_vld = -1;
        dc0       = done_cnt;
        n0        = cyc;
        start_i   = 1'b1;
        len_i     = (ADDR_W+1)'(len);
        @(posedge clk); #1;
        start_i   = 1'b0;
    endtask

    task automatic wait_done(input int len, input bit full_lat, input bit poke, input int n0, input int dc0);
        int budget = 0;
        while (done_cnt == dc0 && budget < 400) begin
            if (poke && budget == 3 && busy_o) begin
                start_i = 1'b1;
                len_i   = (ADDR_W+1)'($urandom_range(1, DEPTH));
            end
            @(posedge clk); #1;
            start_i = 1'b0;
            budget++;
        end
        chk("done_seen", done_cnt != dc0, 1);
        chk("busy_after_done", busy_o, 0);
        if (len == 0) begin
            chk("no_read", first_rd, -1);
            chk("no_valid", first_vld, -1);
        end else begin
            chk("first_read_lat", first_rd - n0, 1);
            chk("first_valid_lat", first_vld - n0, 2);
        end
        if (full_lat) chk("done_lat", done_cyc - n0, len + 2);
        repeat (3) begin @(posedge clk); #1; end
        chk("done_once", done_cnt - dc0, 1);
        chk("words_left", exp_q.size(), 0);
        chk("reads_left", addr_q.size(), 0);
        chk("outstanding_end", out_n, 0);
    endtask

    task automatic drain(input int len, input int mode, input bit poke);
        int n0;
        int dc0;
        rmode = mode;
        @(posedge clk); #1;
        start_drain(len, n0, dc0);
        wait_done(len, mode == 0, poke, n0, dc0);
    endtask

    initial begin
        int n0;
        int dc0;
        int a0;
        int b;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_zero_outputs("reset");
        repeat (20) begin
            @(posedge clk); #1;
            chk("idle_rd", mem_rd_en_o, 0);
        end

        preload(1'b0);
        drain(8, 0, 1'b0);
        preload(1'b0);
        drain(4, 1, 1'b0);
        drain(0, 0, 1'b0);
        preload(1'b1);
        drain(DEPTH, 0, 1'b0);

        // Reset in the middle of a 16-word drain
        preload(1'b0);
        rmode = 0;
        @(posedge clk); #1;
        start_drain(16, n0, dc0);
        a0 = acc_cnt;
        b  = 0;
        while (acc_cnt < a0 + 3 && b < 100) begin
            @(posedge clk); #1;
            b++;
        end
        chk("three_words", acc_cnt - a0, 3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_zero_outputs("midrst");
        repeat (5) begin @(posedge clk); #1; end
        chk("no_done_after_rst", done_cnt, dc0);
        preload(1'b0);
        drain(2, 2, 1'b0);

        // Randomized drains; memory reloaded only occasionally so clear-on-read carries across drains
        for (int t = 0; t < 14; t++) begin
            if (t % 4 == 0) preload(1'b1);
            drain($urandom_range(0, DEPTH), $urandom_range(0, 2), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
